mpu_hm_fetch: RTL

Host-memory fetch engine that sits directly downstream of the MPU's host-memory port. It consumes `hm_addr`/`hm_start`, performs a 64-bit read as two 32-bit Wishbone-classic beats, and returns `hm_data`. It also drives the MPU's `en` input low so the instruction stalls until the data is valid. Bus errors and timeouts are folded into a sticky `error` flag.

---
 rtl/mpu_hm_fetch_pkg.sv | 26 ++
 rtl/mpu_hm_fetch_if.sv | 33 +++
 rtl/mpu_hm_timeout.sv | 38 +++
 rtl/mpu_hm_fetch.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/mpu_hm_fetch_pkg.sv
// rtl/mpu_hm_fetch_pkg.sv - shared definitions for the MPU host-memory fetch engine
//
// Holds the fetch FSM state encoding, the data value returned after a failed
// fetch, the bus geometry (32-bit beats, two beats per doubleword) and the
// width helper for the beat timeout counter.
package mpu_hm_fetch_pkg;

  typedef enum logic [1:0] {
    MPU_HMF_IDLE = 2'd0,
    MPU_HMF_LO   = 2'd1,
    MPU_HMF_HI   = 2'd2,
    MPU_HMF_DONE = 2'd3
  } mpu_hmf_state_e;

  localparam int MPU_HM_BUS_DW = 32;
  localparam int MPU_HM_BEATS  = 2;
  localparam int MPU_HM_DW     = MPU_HM_BUS_DW * MPU_HM_BEATS;

  localparam logic [MPU_HM_DW-1:0] MPU_HM_ERR_DATA = '1;

  // Counter width for a timeout of 'timeout' cycles; never narrower than 1 bit.
  function automatic int mpu_hm_cnt_w(input int timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/mpu_hm_fetch_if.sv
// rtl/mpu_hm_fetch_if.sv - Wishbone-classic read port of the host-memory fetch engine
//
// Signals:
//   wb_adr_o  64-bit byte address of the current beat
//   wb_cyc_o  bus cycle
//   wb_stb_o  strobe
//   wb_sel_o  byte selects (all lanes)
//   wb_dat_i  read data of the current beat
//   wb_ack_i  beat acknowledge
//   wb_err_i  beat error
// Modports: master (fetch engine), slave (memory side).
interface mpu_hm_fetch_if;
  import mpu_hm_fetch_pkg::*;

  logic [63:0]                wb_adr_o;
  logic                       wb_cyc_o;
  logic                       wb_stb_o;
  logic [MPU_HM_BUS_DW/8-1:0] wb_sel_o;
  logic [MPU_HM_BUS_DW-1:0]   wb_dat_i;
  logic                       wb_ack_i;
  logic                       wb_err_i;

  modport master (
    output wb_adr_o, wb_cyc_o, wb_stb_o, wb_sel_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  modport slave (
    input  wb_adr_o, wb_cyc_o, wb_stb_o, wb_sel_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );

endinterface

// File: rtl/mpu_hm_timeout.sv
// rtl/mpu_hm_timeout.sv - per-beat timeout down-counter
//
// Ports:
//   clk      clock
//   rst_n    asynchronous active-low reset
//   clr      reload to TIMEOUT-1 (has priority over en)
//   en       count down by one, saturating at zero
//   expired  counter is zero: the current cycle is the last one a beat may wait
module mpu_hm_timeout
  import mpu_hm_fetch_pkg::*;
#(
  parameter int TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int            CW   = mpu_hm_cnt_w(TIMEOUT);
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= LOAD;
    end else if (clr) begin
      cnt_q <= LOAD;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/mpu_hm_fetch.sv
// rtl/mpu_hm_fetch.sv - 64-bit host-memory fetch as two 32-bit Wishbone-classic beats
//
// Ports:
//   sys_clk   clock
//   sys_rst   asynchronous active-low reset
//   en        global run enable
//   mpu_en    enable to the MPU; low while a fetch is in flight
//   hm_addr   doubleword byte address (bits [2:0] ignored)
//   hm_start  fetch request, held while the requesting instruction is current
//   hm_data   fetched doubleword (ERR_DATA after a failed fetch)
//   err_clr   clears the sticky error flag
//   error     sticky fetch-failure flag (bus error or beat timeout)
//   wb        Wishbone master port
module mpu_hm_fetch
  import mpu_hm_fetch_pkg::*;
#(
  parameter int                    TIMEOUT  = 256,
  parameter logic [MPU_HM_DW-1:0]  ERR_DATA = MPU_HM_ERR_DATA
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 en,
  output logic                 mpu_en,
  input  logic [63:0]          hm_addr,
  input  logic                 hm_start,
  output logic [MPU_HM_DW-1:0] hm_data,
  input  logic                 err_clr,
  output logic                 error,
  mpu_hm_fetch_if.master       wb
);

  localparam int BEAT_BYTES = MPU_HM_BUS_DW / 8;

  mpu_hmf_state_e state_q, state_d;

  logic                 cyc_q;
  logic [63:0]          adr_q;
  logic [MPU_HM_DW-1:0] data_q;
  logic                 error_q;

  logic start_fetch;
  logic beat_ok;
  logic abort;
  logic in_beat;
  logic tmr_expired;

  // Alignment bits of the request are dropped on purpose.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^hm_addr[2:0];

  assign in_beat = (state_q == MPU_HMF_LO) || (state_q == MPU_HMF_HI);

  // Reloaded outside beats and on every ack, so each beat gets a full budget.
  mpu_hm_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (sys_clk),
    .rst_n   (sys_rst),
    .clr     (~in_beat | wb.wb_ack_i),
    .en      (in_beat),
    .expired (tmr_expired)
  );

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q <= MPU_HMF_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    start_fetch = 1'b0;
    beat_ok     = 1'b0;
    abort       = 1'b0;
    mpu_en      = 1'b0;
    case (state_q)
      MPU_HMF_IDLE: begin
        mpu_en = en & ~hm_start;
        if (hm_start && en) begin
          start_fetch = 1'b1;
          state_d     = MPU_HMF_LO;
        end
      end
      MPU_HMF_LO, MPU_HMF_HI: begin
        // Error beats ack; an ack in the last allowed cycle beats the timeout.
        if (wb.wb_err_i || (tmr_expired && !wb.wb_ack_i)) begin
          abort   = 1'b1;
          state_d = MPU_HMF_DONE;
        end else if (wb.wb_ack_i) begin
          beat_ok = 1'b1;
          state_d = (state_q == MPU_HMF_LO) ? MPU_HMF_HI : MPU_HMF_DONE;
        end
      end
      MPU_HMF_DONE: begin
        // The request is still high here; returning to IDLE without looking
        // at it keeps the completing instruction from fetching twice.
        mpu_en  = en;
        state_d = MPU_HMF_IDLE;
      end
      default: state_d = MPU_HMF_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      cyc_q  <= 1'b0;
      adr_q  <= '0;
      data_q <= '0;
    end else if (start_fetch) begin
      cyc_q <= 1'b1;
      adr_q <= {hm_addr[63:3], 3'b000};
    end else if (abort) begin
      cyc_q  <= 1'b0;
      data_q <= ERR_DATA;
    end else if (beat_ok) begin
      if (state_q == MPU_HMF_LO) begin
        data_q[MPU_HM_BUS_DW-1:0] <= wb.wb_dat_i;
        adr_q                     <= adr_q + 64'(BEAT_BYTES);
      end else begin
        data_q[MPU_HM_DW-1:MPU_HM_BUS_DW] <= wb.wb_dat_i;
        cyc_q                             <= 1'b0;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      error_q <= 1'b0;
    end else if (abort) begin
      error_q <= 1'b1;
    end else if (err_clr) begin
      error_q <= 1'b0;
    end
  end

  assign wb.wb_adr_o = adr_q;
  assign wb.wb_cyc_o = cyc_q;
  assign wb.wb_stb_o = cyc_q;
  assign wb.wb_sel_o = '1;
  assign hm_data     = data_q;
  assign error       = error_q;

endmodule
